// File: rtl/mem_access_pkg.sv
// Shared widths, inst-type codes and write-back constants for the MEM-stage access unit.
package mem_access_pkg;

   localparam int unsigned RegBus      = 32;
   localparam int unsigned RegAddrBus  = 5;
   localparam int unsigned InstAddrBus = 32;
   localparam int unsigned InstTypeBus = 6;
   localparam int unsigned ByteW       = 8;

   localparam logic [InstTypeBus-1:0] EXE_LB  = 6'd11;
   localparam logic [InstTypeBus-1:0] EXE_LH  = 6'd12;
   localparam logic [InstTypeBus-1:0] EXE_LW  = 6'd13;
   localparam logic [InstTypeBus-1:0] EXE_LBU = 6'd14;
   localparam logic [InstTypeBus-1:0] EXE_LHU = 6'd15;
   localparam logic [InstTypeBus-1:0] EXE_SB  = 6'd16;
   localparam logic [InstTypeBus-1:0] EXE_SH  = 6'd17;
   localparam logic [InstTypeBus-1:0] EXE_SW  = 6'd18;

   localparam logic [RegBus-1:0]     ZeroWord     = 32'h0000_0000;
   localparam logic [RegAddrBus-1:0] NOPRegAdder  = 5'd0;
   localparam logic                  Stop         = 1'b1;
   localparam logic                  NotStop      = 1'b0;
   localparam logic                  WriteEnable  = 1'b1;
   localparam logic                  WriteDisable = 1'b0;

   // Number of bytes moved by an access of the given type (word for anything unknown).
   function automatic logic [2:0] access_bytes(input logic [InstTypeBus-1:0] t);
      case (t)
         EXE_LB, EXE_LBU, EXE_SB: access_bytes = 3'd1;
         EXE_LH, EXE_LHU, EXE_SH: access_bytes = 3'd2;
         default:                 access_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Assembles the four captured load bytes and sign/zero-extends them by inst type.
module load_extend
   import mem_access_pkg::*;
(
   input  logic [RegBus-1:0]      word,
   input  logic [InstTypeBus-1:0] inst_type,
   output logic [RegBus-1:0]      value
);

   always_comb begin
      value = word;
      case (inst_type)
         EXE_LB:  value = {{24{word[7]}}, word[7:0]};
         EXE_LBU: value = {24'h000000, word[7:0]};
         EXE_LH:  value = {{16{word[15]}}, word[15:0]};
         EXE_LHU: value = {16'h0000, word[15:0]};
         default: value = word;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM-stage memory access unit: serialises loads/stores onto an 8-bit RAM port.
// Optional performance counters enabled by defining MEM_ACCESS_PERF_EN.
module mem_access
   import mem_access_pkg::*;
(
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic [5:0]             stall,
   input  logic                   rd_mem_in,
   input  logic [RegBus-1:0]      rd_val_mem_in,
   input  logic [RegAddrBus-1:0]  rd_addr_mem_in,
   input  logic [InstTypeBus-1:0] inst_type_mem_in,
   input  logic                   load_mem_in,
   input  logic                   store_mem_in,
   input  logic [InstAddrBus-1:0] mem_addr_mem_in,
   input  logic [RegBus-1:0]      mem_val_mem_in,
   input  logic                   mem_busy_in,
   input  logic [ByteW-1:0]       mem_din_in,
   output logic                   mem_req_out,
   output logic                   mem_wr_out,
   output logic [InstAddrBus-1:0] mem_a_out,
   output logic [ByteW-1:0]       mem_dout_out,
   output logic                   rd_wb_out,
   output logic [RegBus-1:0]      rd_val_wb_out,
   output logic [RegAddrBus-1:0]  rd_addr_wb_out,
   output logic                   stallreq_mem_out,
   output logic [31:0]            load_cnt_out,
   output logic [31:0]            store_cnt_out,
   output logic [31:0]            stall_cnt_out
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   state_t                 state, state_nxt;
   logic [InstAddrBus-1:0] addr;
   logic [RegBus-1:0]      data;
   logic [InstTypeBus-1:0] itype;
   logic                   is_load;
   logic [RegAddrBus-1:0]  rd_addr;
   logic [2:0]             n, idx;
   logic                   pend_valid;
   logic [1:0]             pend_idx;
   logic [RegBus-1:0]      ld_word, ld_val;
   logic                   start, issue;
   logic                   unused_stall;

   assign unused_stall = ^{stall[5], stall[3:0]};

   load_extend u_load_extend (
      .word      (ld_word),
      .inst_type (itype),
      .value     (ld_val)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and port drive; everything is gated by rdy_in except the IDLE pass-through.
   always_comb begin
      state_nxt        = state;
      start            = 1'b0;
      issue            = 1'b0;
      mem_req_out      = 1'b0;
      mem_wr_out       = WriteDisable;
      mem_a_out        = ZeroWord;
      mem_dout_out     = 8'h00;
      rd_wb_out        = WriteDisable;
      rd_val_wb_out    = ZeroWord;
      rd_addr_wb_out   = NOPRegAdder;
      stallreq_mem_out = 1'b0;
      case (state)
         IDLE: begin
            if (load_mem_in || store_mem_in) begin
               stallreq_mem_out = 1'b1;
               start            = rdy_in;
               if (rdy_in) state_nxt = ACCESS;
            end else begin
               rd_wb_out      = rd_mem_in;
               rd_val_wb_out  = rd_val_mem_in;
               rd_addr_wb_out = rd_addr_mem_in;
            end
         end
         ACCESS: begin
            stallreq_mem_out = 1'b1;
            if (rdy_in && !mem_busy_in) begin
               issue       = 1'b1;
               mem_req_out = 1'b1;
               mem_a_out   = addr + InstAddrBus'(idx);
               if (!is_load) begin
                  mem_wr_out   = WriteEnable;
                  mem_dout_out = data[{idx[1:0], 3'b000} +: 8];
               end
               if (idx == n - 3'd1) state_nxt = is_load ? WAIT : DONE;
            end
         end
         WAIT: begin
            stallreq_mem_out = 1'b1;
            if (rdy_in) state_nxt = DONE;
         end
         DONE: begin
            if (is_load) begin
               rd_wb_out      = WriteEnable;
               rd_val_wb_out  = ld_val;
               rd_addr_wb_out = rd_addr;
            end
            if (rdy_in && stall[4] == NotStop) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, byte index and load-byte capture (capture ignores rdy/busy).
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         addr       <= ZeroWord;
         data       <= ZeroWord;
         itype      <= '0;
         is_load    <= 1'b0;
         rd_addr    <= NOPRegAdder;
         n          <= 3'd0;
         idx        <= 3'd0;
         pend_valid <= 1'b0;
         pend_idx   <= 2'd0;
         ld_word    <= ZeroWord;
      end else begin
         pend_valid <= issue && is_load;
         pend_idx   <= idx[1:0];
         if (pend_valid) ld_word[{pend_idx, 3'b000} +: 8] <= mem_din_in;
         if (start) begin
            addr    <= mem_addr_mem_in;
            data    <= mem_val_mem_in;
            itype   <= inst_type_mem_in;
            is_load <= load_mem_in;
            rd_addr <= rd_addr_mem_in;
            n       <= access_bytes(inst_type_mem_in);
            idx     <= 3'd0;
            ld_word <= ZeroWord;
         end else if (issue) begin
            idx <= idx + 3'd1;
         end
      end
   end

`ifdef MEM_ACCESS_PERF_EN
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         load_cnt_out  <= 32'd0;
         store_cnt_out <= 32'd0;
         stall_cnt_out <= 32'd0;
      end else if (rdy_in) begin
         if (start && load_mem_in)                load_cnt_out  <= load_cnt_out + 32'd1;
         if (start && !load_mem_in && store_mem_in) store_cnt_out <= store_cnt_out + 32'd1;
         if (stallreq_mem_out)                     stall_cnt_out <= stall_cnt_out + 32'd1;
      end
   end
`else
   assign load_cnt_out  = 32'd0;
   assign store_cnt_out = 32'd0;
   assign stall_cnt_out = 32'd0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access with a byte-wide RAM model.
// Counter expectations follow MEM_ACCESS_PERF_EN.
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, rd_mem_in, load_mem_in, store_mem_in, mem_busy_in;
   logic [5:0]  stall;
   logic [31:0] rd_val_mem_in, mem_addr_mem_in, mem_val_mem_in;
   logic [4:0]  rd_addr_mem_in;
   logic [5:0]  inst_type_mem_in;
   logic [7:0]  mem_din_in;
   logic        mem_req_out, mem_wr_out, rd_wb_out, stallreq_mem_out;
   logic [31:0] mem_a_out, rd_val_wb_out, load_cnt_out, store_cnt_out, stall_cnt_out;
   logic [7:0]  mem_dout_out;
   logic [4:0]  rd_addr_wb_out;

   logic [7:0]  ram [1024];
   int          wr_cnt = 0;
   int          vecs = 0;
   int          errs = 0;
   int          w0;

`ifdef MEM_ACCESS_PERF_EN
   localparam logic [31:0] ExpLd = 32'd1, ExpSt = 32'd1, ExpStall = 32'd8;
`else
   localparam logic [31:0] ExpLd = 32'd0, ExpSt = 32'd0, ExpStall = 32'd0;
`endif

   always #5 clk_in = ~clk_in;

   mem_access dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall(stall),
      .rd_mem_in(rd_mem_in), .rd_val_mem_in(rd_val_mem_in), .rd_addr_mem_in(rd_addr_mem_in),
      .inst_type_mem_in(inst_type_mem_in), .load_mem_in(load_mem_in), .store_mem_in(store_mem_in),
      .mem_addr_mem_in(mem_addr_mem_in), .mem_val_mem_in(mem_val_mem_in),
      .mem_busy_in(mem_busy_in), .mem_din_in(mem_din_in),
      .mem_req_out(mem_req_out), .mem_wr_out(mem_wr_out), .mem_a_out(mem_a_out),
      .mem_dout_out(mem_dout_out), .rd_wb_out(rd_wb_out), .rd_val_wb_out(rd_val_wb_out),
      .rd_addr_wb_out(rd_addr_wb_out), .stallreq_mem_out(stallreq_mem_out),
      .load_cnt_out(load_cnt_out), .store_cnt_out(store_cnt_out), .stall_cnt_out(stall_cnt_out)
   );

   // RAM: read data appears the cycle after the address; writes are counted.
   always @(posedge clk_in) begin
      if (mem_req_out && !mem_wr_out) mem_din_in <= ram[mem_a_out[9:0]];
      if (mem_req_out && mem_wr_out)  wr_cnt <= wr_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic to_mid();
      @(negedge clk_in);
   endtask

   task automatic to_next();
      @(posedge clk_in);
      #1;
   endtask

   // Cycle 0: present a request for one cycle, then withdraw it.
   task automatic do_start(input logic ld, input logic st, input logic [5:0] t,
                           input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
      load_mem_in = ld; store_mem_in = st; inst_type_mem_in = t;
      mem_addr_mem_in = a; mem_val_mem_in = d; rd_addr_mem_in = rd;
      to_mid();
      chk("start_stallreq", 32'(stallreq_mem_out), 32'd1);
      to_next();
      load_mem_in = 1'b0; store_mem_in = 1'b0; rd_addr_mem_in = 5'd0;
   endtask

   initial begin
      ram[10'h100] = 8'h78; ram[10'h101] = 8'h56; ram[10'h102] = 8'h34; ram[10'h103] = 8'h12;
      ram[10'h040] = 8'h80; ram[10'h041] = 8'h90;
      ram[10'h3FF] = 8'h34; ram[10'h000] = 8'h82;
      mem_din_in = 8'h00;
      rst_in = 1'b1; rdy_in = 1'b1; stall = 6'd0; mem_busy_in = 1'b0;
      load_mem_in = 1'b0; store_mem_in = 1'b0; inst_type_mem_in = 6'd0;
      mem_addr_mem_in = 32'd0; mem_val_mem_in = 32'd0;
      rd_mem_in = 1'b1; rd_val_mem_in = 32'hA5A5_0001; rd_addr_mem_in = 5'd7;

      // Reset: idle pass-through, no RAM traffic, counters clear
      to_mid();
      chk("rst_req", 32'(mem_req_out), 32'd0);
      chk("rst_stallreq", 32'(stallreq_mem_out), 32'd0);
      chk("rst_pass_wb", 32'(rd_wb_out), 32'd1);
      chk("rst_pass_val", rd_val_wb_out, 32'hA5A5_0001);
      chk("rst_pass_addr", 32'(rd_addr_wb_out), 32'd7);
      chk("rst_ldcnt", load_cnt_out, 32'd0);
      chk("rst_stcnt", store_cnt_out, 32'd0);
      chk("rst_stallcnt", stall_cnt_out, 32'd0);
      to_next();
      rst_in = 1'b0; rd_mem_in = 1'b0; rd_val_mem_in = 32'd0; rd_addr_mem_in = 5'd0;
      to_next();

      // LW @0x100
      do_start(1'b1, 1'b0, EXE_LW, 32'h100, 32'd0, 5'd5);
      for (int i = 0; i < 4; i++) begin
         to_mid();
         chk("lw_req", 32'(mem_req_out), 32'd1);
         chk("lw_addr", mem_a_out, 32'h100 + 32'(i));
         chk("lw_wr", 32'(mem_wr_out), 32'd0);
         to_next();
      end
      to_mid();
      chk("lw_wait_req", 32'(mem_req_out), 32'd0);
      chk("lw_wait_stall", 32'(stallreq_mem_out), 32'd1);
      to_next();
      to_mid();
      chk("lw_done_stall", 32'(stallreq_mem_out), 32'd0);
      chk("lw_done_wb", 32'(rd_wb_out), 32'd1);
      chk("lw_done_val", rd_val_wb_out, 32'h1234_5678);
      chk("lw_done_rd", 32'(rd_addr_wb_out), 32'd5);
      to_next();
      to_mid();
      chk("lw_idle_wb", 32'(rd_wb_out), 32'd0);
      to_next();

      // SB @0x30, then performance counters
      do_start(1'b0, 1'b1, EXE_SB, 32'h30, 32'h0000_00AB, 5'd9);
      to_mid();
      chk("sb_req", 32'(mem_req_out), 32'd1);
      chk("sb_wr", 32'(mem_wr_out), 32'd1);
      chk("sb_addr", mem_a_out, 32'h30);
      chk("sb_dout", 32'(mem_dout_out), 32'hAB);
      to_next();
      to_mid();
      chk("sb_done_stall", 32'(stallreq_mem_out), 32'd0);
      chk("sb_done_wb", 32'(rd_wb_out), 32'd0);
      chk("cnt_load", load_cnt_out, ExpLd);
      chk("cnt_store", store_cnt_out, ExpSt);
      chk("cnt_stall", stall_cnt_out, ExpStall);
      to_next();

      // LB / LBU of byte 0x80
      for (int k = 0; k < 2; k++) begin
         do_start(1'b1, 1'b0, (k == 0) ? EXE_LB : EXE_LBU, 32'h40, 32'd0, 5'd2);
         to_mid();
         chk("lb_addr", mem_a_out, 32'h40);
         chk("lb_req", 32'(mem_req_out), 32'd1);
         to_next();
         to_mid();
         chk("lb_wait_req", 32'(mem_req_out), 32'd0);
         chk("lb_wait_stall", 32'(stallreq_mem_out), 32'd1);
         to_next();
         to_mid();
         chk("lb_done_wb", 32'(rd_wb_out), 32'd1);
         chk("lb_done_val", rd_val_wb_out, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
         to_next();
      end

      // SH @0x20 of 0xDEADBEEF
      do_start(1'b0, 1'b1, EXE_SH, 32'h20, 32'hDEAD_BEEF, 5'd4);
      to_mid();
      chk("sh_a0", mem_a_out, 32'h20);
      chk("sh_d0", 32'(mem_dout_out), 32'hEF);
      chk("sh_wr0", 32'(mem_wr_out), 32'd1);
      to_next();
      to_mid();
      chk("sh_a1", mem_a_out, 32'h21);
      chk("sh_d1", 32'(mem_dout_out), 32'hBE);
      to_next();
      to_mid();
      chk("sh_done_stall", 32'(stallreq_mem_out), 32'd0);
      chk("sh_done_wb", 32'(rd_wb_out), 32'd0);
      chk("sh_done_req", 32'(mem_req_out), 32'd0);
      to_next();

      // LW with RAM port busy in cycles 2-3
      do_start(1'b1, 1'b0, EXE_LW, 32'h100, 32'd0, 5'd3);
      to_mid();
      chk("busy_a0", mem_a_out, 32'h100);
      to_next();
      mem_busy_in = 1'b1;
      for (int i = 0; i < 2; i++) begin
         to_mid();
         chk("busy_noreq", 32'(mem_req_out), 32'd0);
         chk("busy_stall", 32'(stallreq_mem_out), 32'd1);
         to_next();
      end
      mem_busy_in = 1'b0;
      for (int i = 1; i < 4; i++) begin
         to_mid();
         chk("busy_req", 32'(mem_req_out), 32'd1);
         chk("busy_addr", mem_a_out, 32'h100 + 32'(i));
         to_next();
      end
      to_mid();
      chk("busy_wait_req", 32'(mem_req_out), 32'd0);
      to_next();
      to_mid();
      chk("busy_done_wb", 32'(rd_wb_out), 32'd1);
      chk("busy_done_val", rd_val_wb_out, 32'h1234_5678);
      to_next();

      // LH held in DONE by stall[4]
      do_start(1'b1, 1'b0, EXE_LH, 32'h40, 32'd0, 5'd6);
      to_next();
      to_next();
      to_next();
      stall = 6'b010000;
      for (int i = 0; i < 3; i++) begin
         to_mid();
         chk("hold_wb", 32'(rd_wb_out), 32'd1);
         chk("hold_val", rd_val_wb_out, 32'hFFFF_9080);
         chk("hold_noreq", 32'(mem_req_out), 32'd0);
         to_next();
      end
      stall = 6'd0;
      to_mid();
      chk("hold_release_val", rd_val_wb_out, 32'hFFFF_9080);
      to_next();
      to_mid();
      chk("hold_idle_wb", 32'(rd_wb_out), 32'd0);
      chk("hold_idle_stall", 32'(stallreq_mem_out), 32'd0);
      to_next();

      // Reset during SW aborts after the first byte
      w0 = wr_cnt;
      do_start(1'b0, 1'b1, EXE_SW, 32'h50, 32'h1122_3344, 5'd1);
      to_mid();
      chk("swr_d0", 32'(mem_dout_out), 32'h44);
      chk("swr_wr0", 32'(mem_wr_out), 32'd1);
      to_next();
      rst_in = 1'b1;
      #1;
      chk("swr_rst_req", 32'(mem_req_out), 32'd0);
      chk("swr_rst_wr", 32'(mem_wr_out), 32'd0);
      chk("swr_rst_stall", 32'(stallreq_mem_out), 32'd0);
      to_next();
      to_next();
      rst_in = 1'b0;
      for (int i = 0; i < 4; i++) to_next();
      chk("swr_wr_count", 32'(wr_cnt - w0), 32'd1);
      chk("swr_stallcnt", stall_cnt_out, 32'd0);

      // LH across the address wrap
      do_start(1'b1, 1'b0, EXE_LH, 32'hFFFF_FFFF, 32'd0, 5'd8);
      to_mid();
      chk("wrap_a0", mem_a_out, 32'hFFFF_FFFF);
      to_next();
      to_mid();
      chk("wrap_a1", mem_a_out, 32'h0000_0000);
      to_next();
      to_next();
      to_mid();
      chk("wrap_val", rd_val_wb_out, 32'hFFFF_8234);
      to_next();

      // rdy_in low freezes the access for a cycle
      do_start(1'b0, 1'b1, EXE_SB, 32'h60, 32'h0000_005A, 5'd0);
      rdy_in = 1'b0;
      to_mid();
      chk("rdy_noreq", 32'(mem_req_out), 32'd0);
      chk("rdy_stall", 32'(stallreq_mem_out), 32'd1);
      to_next();
      rdy_in = 1'b1;
      to_mid();
      chk("rdy_req", 32'(mem_req_out), 32'd1);
      chk("rdy_addr", mem_a_out, 32'h60);
      chk("rdy_dout", 32'(mem_dout_out), 32'h5A);
      to_next();
      to_mid();
      chk("rdy_done_stall", 32'(stallreq_mem_out), 32'd0);
      to_next();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
